// File: rtl/tank_cmd_scheduler.sv
// tank_cmd_scheduler
// Queues one-hot keyboard operations and hands them to the tank datapath,
// at most one per game tick, over a valid/ready handshake. A fire command
// is gated by a pending flag (one fire in flight at a time) and by a
// tick-based cooldown that starts when the fire command is accepted.
module tank_cmd_scheduler #(
  parameter int DEPTH         = 4,
  parameter int CW            = 4,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic [4:0]               key_op,
  input  logic                     tick,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [4:0]               cmd_op,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fire_busy,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // True when exactly one bit of the operation code is set.
  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_cool;
  logic          r_fire_pending;
  state_t        r_state;
  logic          r_cmd_valid;
  logic [4:0]    r_cmd_op;
  logic          r_fire_busy;
  logic          r_drop;

  state_t        w_state_next;
  logic [AW:0]   w_count_next;
  logic [CW-1:0] w_cool_next;
  logic          w_onehot;
  logic          w_full;
  logic          w_handshake;
  logic          w_fire_hs;
  logic          w_pop;
  logic          w_fire_block;
  logic          w_push;
  logic          w_reject;

  assign w_onehot     = is_onehot5(key_op);
  assign w_full       = (r_count == (AW + 1)'(DEPTH));
  assign w_handshake  = r_cmd_valid && cmd_ready;
  assign w_fire_hs    = w_handshake && r_cmd_op[4];
  // Only ARMED dispatches, so ticks seen in IDLE/ISSUE are simply dropped.
  assign w_pop        = (r_state == ST_ARMED) && tick;
  assign w_fire_block = key_op[4] && ((r_cool != '0) || r_fire_pending);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push       = w_onehot && !w_fire_block && (!w_full || w_pop);
  assign w_reject     = w_onehot && !w_push;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW + 1)'(1);
      2'b01:   w_count_next = r_count - (AW + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Cooldown: a fire handshake reloads (and beats a same-cycle tick), ticks count down to 0.
  always_comb begin
    w_cool_next = r_cool;
    if (w_fire_hs) begin
      w_cool_next = CW'(FIRE_COOLDOWN);
    end else if (tick && (r_cool != '0)) begin
      w_cool_next = r_cool - CW'(1);
    end else begin
      w_cool_next = r_cool;
    end
  end

  // Dispatch FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_count_next != '0) begin
          w_state_next = ST_ARMED;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (w_pop) begin
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ISSUE: begin
        if (w_handshake) begin
          w_state_next = (w_count_next != '0) ? ST_ARMED : ST_IDLE;
        end else begin
          w_state_next = ST_ISSUE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Dispatch FSM state register.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO storage; entries need no reset because only occupied slots are read.
  always_ff @(posedge clk_100mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= key_op;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Fire bookkeeping: one fire in flight, then cooldown.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_fire_pending <= 1'b0;
      r_cool         <= '0;
      r_fire_busy    <= 1'b0;
    end else begin
      if (w_push && key_op[4]) begin
        r_fire_pending <= 1'b1;
      end else if (w_fire_hs) begin
        r_fire_pending <= 1'b0;
      end
      r_cool      <= w_cool_next;
      r_fire_busy <= (w_cool_next != '0);
    end
  end

  // Command output register; op is cleared once the command is taken.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 5'd0;
      r_drop      <= 1'b0;
    end else begin
      r_cmd_valid <= (w_state_next == ST_ISSUE);
      if (w_pop) begin
        r_cmd_op <= r_mem[r_rd_ptr];
      end else if (w_handshake) begin
        r_cmd_op <= 5'd0;
      end
      r_drop <= w_reject;
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_op     = r_cmd_op;
  assign fifo_count = r_count;
  assign fire_busy  = r_fire_busy;
  assign drop       = r_drop;

endmodule

// File: tb/tb_tank_cmd_scheduler.sv
// Bench for tank_cmd_scheduler: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_tank_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int COOL  = 8;

  logic       clk_100mhz = 1'b0;
  logic       rst        = 1'b1;
  logic [4:0] key_op     = 5'd0;
  logic       tick       = 1'b0;
  logic       cmd_ready  = 1'b0;
  logic       cmd_valid;
  logic [4:0] cmd_op;
  logic [2:0] fifo_count;
  logic       fire_busy;
  logic       drop;

  int n_checks = 0;
  int n_fail   = 0;

  tank_cmd_scheduler #(.DEPTH(DEPTH), .CW(4), .FIRE_COOLDOWN(COOL)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .key_op     (key_op),
    .tick       (tick),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .fifo_count (fifo_count),
    .fire_busy  (fire_busy),
    .drop       (drop)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] m_q[$];
  logic       m_valid = 1'b0;
  logic [4:0] m_op    = 5'd0;
  int         m_cd    = 0;
  logic       m_pend  = 1'b0;
  logic       m_drop  = 1'b0;
  logic       m_live  = 1'b0;
  logic       m_hs, m_pop, m_one, m_blk, m_acc;

  always @(posedge clk_100mhz) begin
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0; m_op = 5'd0; m_cd = 0; m_pend = 1'b0; m_drop = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_hs   = m_valid && cmd_ready;
      m_pop  = !m_valid && (m_q.size() != 0) && tick;
      m_one  = ($countones(key_op) == 1);
      m_blk  = key_op[4] && ((m_cd != 0) || m_pend);
      m_acc  = m_one && !m_blk && ((m_q.size() < DEPTH) || m_pop);
      m_drop = m_one && !m_acc;
      if (m_hs && m_op[4]) begin
        m_cd   = COOL;
        m_pend = 1'b0;
      end else if (tick && m_cd > 0) begin
        m_cd = m_cd - 1;
      end
      if (m_hs) begin
        m_valid = 1'b0;
        m_op    = 5'd0;
      end
      if (m_pop) begin
        m_op    = m_q.pop_front();
        m_valid = 1'b1;
      end
      if (m_acc) begin
        m_q.push_back(key_op);
        if (key_op[4]) m_pend = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_100mhz) begin
    if (m_live) begin
      chk("model_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
      chk("model_op",    {27'd0, cmd_op},    {27'd0, m_op});
      chk("model_count", {29'd0, fifo_count}, 32'(m_q.size()));
      chk("model_busy",  {31'd0, fire_busy}, {31'd0, (m_cd != 0)});
      chk("model_drop",  {31'd0, drop},      {31'd0, m_drop});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [4:0] k, input logic t);
    key_op = k;
    tick   = t;
    @(posedge clk_100mhz);
    #1;
    key_op = 5'd0;
    tick   = 1'b0;
  endtask

  task automatic drain();
    int i;
    cmd_ready = 1'b1;
    for (i = 0; i < 40; i++) begin
      if (fifo_count == 3'd0 && !cmd_valid) break;
      step(5'd0, 1'b1);
    end
    chk("drain_done", {31'd0, (fifo_count == 3'd0 && !cmd_valid)}, 32'd1);
  endtask

  logic [4:0] seq_op [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_op[0] = 5'b00100; seq_op[1] = 5'b01000;
    seq_op[2] = 5'b00001; seq_op[3] = 5'b00010;

    // Reset state
    rst = 1'b1;
    step(5'd0, 1'b0);
    step(5'd0, 1'b0);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_busy",  {31'd0, fire_busy}, 32'd0);
    chk("rst_op",    {27'd0, cmd_op}, 32'd0);
    rst = 1'b0;

    // Single move: push, tick later, handshake
    cmd_ready = 1'b1;
    repeat (3) step(5'd0, 1'b0);
    step(5'b00100, 1'b0);
    chk("t1_count", {29'd0, fifo_count}, 32'd1);
    repeat (4) step(5'd0, 1'b0);
    chk("t1_wait_valid", {31'd0, cmd_valid}, 32'd0);
    step(5'd0, 1'b1);
    chk("t1_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t1_op",    {27'd0, cmd_op}, 32'h04);
    step(5'd0, 1'b0);
    chk("t1_valid_off", {31'd0, cmd_valid}, 32'd0);
    chk("t1_count_off", {29'd0, fifo_count}, 32'd0);

    // w, a, d, s back to back, one per 20-cycle tick
    step(5'b00100, 1'b0);
    step(5'b01000, 1'b0);
    step(5'b00001, 1'b0);
    step(5'b00010, 1'b0);
    chk("t2_count", {29'd0, fifo_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      repeat (19) step(5'd0, 1'b0);
      step(5'd0, 1'b1);
      chk("t2_valid", {31'd0, cmd_valid}, 32'd1);
      chk("t2_op",    {27'd0, cmd_op}, {27'd0, seq_op[i]});
      step(5'd0, 1'b0);
      chk("t2_one_per_tick", {31'd0, cmd_valid}, 32'd0);
    end

    // Full FIFO: fifth push drops; with a same-cycle pop it is accepted
    cmd_ready = 1'b0;
    repeat (4) step(5'b00001, 1'b0);
    chk("t3_full", {29'd0, fifo_count}, 32'd4);
    step(5'b00001, 1'b0);
    chk("t3_drop", {31'd0, drop}, 32'd1);
    chk("t3_count", {29'd0, fifo_count}, 32'd4);
    step(5'd0, 1'b0);
    chk("t3_drop_pulse", {31'd0, drop}, 32'd0);
    step(5'b01000, 1'b1);
    chk("t3_pp_drop",  {31'd0, drop}, 32'd0);
    chk("t3_pp_count", {29'd0, fifo_count}, 32'd4);
    chk("t3_pp_valid", {31'd0, cmd_valid}, 32'd1);
    drain();

    // Fire: pending blocks second fire, then cooldown over 8 ticks
    cmd_ready = 1'b0;
    step(5'b10000, 1'b0);
    chk("t4_fire_acc", {29'd0, fifo_count}, 32'd1);
    step(5'b10000, 1'b0);
    chk("t4_pend_drop", {31'd0, drop}, 32'd1);
    step(5'd0, 1'b1);
    chk("t4_fire_op", {27'd0, cmd_op}, 32'h10);
    cmd_ready = 1'b1;
    step(5'd0, 1'b0);
    chk("t4_busy_start", {31'd0, fire_busy}, 32'd1);
    cmd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        step(5'b10000, 1'b0);
        chk("t4_cool_drop", {31'd0, drop}, 32'd1);
      end
      chk("t4_busy", {31'd0, fire_busy}, 32'd1);
      step(5'd0, 1'b1);
    end
    chk("t4_busy_end", {31'd0, fire_busy}, 32'd0);
    step(5'b10000, 1'b0);
    chk("t4_refire_drop",  {31'd0, drop}, 32'd0);
    chk("t4_refire_count", {29'd0, fifo_count}, 32'd1);
    drain();

    // Stalled handshake: ticks during ISSUE ignored
    cmd_ready = 1'b0;
    step(5'b00100, 1'b0);
    step(5'b00010, 1'b0);
    step(5'd0, 1'b1);
    chk("t5_valid", {31'd0, cmd_valid}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      step(5'd0, (i == 5 || i == 15 || i == 25));
      chk("t5_op_stable", {27'd0, cmd_op}, 32'h04);
      chk("t5_count",     {29'd0, fifo_count}, 32'd1);
    end
    cmd_ready = 1'b1;
    step(5'd0, 1'b0);
    chk("t5_hs", {31'd0, cmd_valid}, 32'd0);
    repeat (3) begin
      step(5'd0, 1'b0);
      chk("t5_wait_tick", {31'd0, cmd_valid}, 32'd0);
    end
    step(5'd0, 1'b1);
    chk("t5_next_op", {27'd0, cmd_op}, 32'h02);
    step(5'd0, 1'b0);
    chk("t5_empty", {29'd0, fifo_count}, 32'd0);

    // Multi-bit op ignored silently; reset during ISSUE
    step(5'b10100, 1'b0);
    chk("t6_multi_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_multi_drop",  {31'd0, drop}, 32'd0);
    cmd_ready = 1'b0;
    step(5'b00100, 1'b0);
    step(5'd0, 1'b1);
    chk("t6_issue", {31'd0, cmd_valid}, 32'd1);
    step(5'b00001, 1'b0);
    rst = 1'b1;
    step(5'd0, 1'b0);
    chk("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_rst_busy",  {31'd0, fire_busy}, 32'd0);
    rst = 1'b0;
    repeat (3) step(5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_cmd_scheduler.md
Name: tank_cmd_scheduler

Overview:
- Sits between the PS/2 keyboard decoder and the player-tank movement/fire datapath.
- Buffers one-hot operation pulses (space/a/w/s/d) in a small FIFO and releases at most one command per game tick over a valid/ready handshake.
- Enforces a fire cooldown so the tank datapath never sees back-to-back shots faster than the game rules allow.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CW, 4, fire-cooldown counter width.
- FIRE_COOLDOWN, 8, game ticks a fire command blocks further fire after it is accepted (must fit in CW bits, ≥1).

Ports:
- clk_100mhz  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_op  in  5  one-hot operation pulse from the keyboard decoder: bit4 fire, bit3 left, bit2 up, bit1 down, bit0 right; 0 = none.
- tick  in  1  one-cycle game-tick strobe.
- cmd_ready  in  1  tank datapath accepts the current command.
- cmd_valid  out  1  command presented.
- cmd_op  out  5  one-hot command; stable while cmd_valid is high.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- fire_busy  out  1  fire cooldown active (counter != 0).
- drop  out  1  one-cycle pulse when a capture is rejected.

Behaviour:
- Reset: synchronous. Clears FIFO pointers/count, the cooldown counter and fire_pending, and returns the FSM to IDLE. All outputs read 0 the cycle after rst is sampled high. Reset in ISSUE abandons the command with no handshake.
- Capture, evaluated each cycle key_op != 0:
  - Accepted only if exactly one bit is set. Multi-bit values are discarded silently (no drop pulse).
  - A fire (bit4) is rejected with drop=1 if the cooldown counter != 0 or fire_pending=1.
  - fire_pending is set when fire is enqueued and cleared when the fire command handshakes.
  - Any op arriving when the FIFO is full and no pop happens that cycle is rejected with drop=1.
  - Push and pop in the same cycle both occur; count is unchanged. A push to a full FIFO with a simultaneous pop is accepted.
- FIFO: circular buffer, pointers wrap modulo DEPTH. fifo_count updates the cycle after push/pop.
- FSM states:
  - IDLE: FIFO empty, cmd_valid=0. Moves to ARMED when fifo_count != 0.
  - ARMED: FIFO non-empty, waiting. When tick=1, pop the head into the cmd_op register; cmd_valid=1 from the next cycle; go to ISSUE.
  - ISSUE: hold cmd_valid/cmd_op until cmd_valid&cmd_ready. On the handshake cycle, cmd_valid drops next cycle; go to ARMED if the FIFO is non-empty after that cycle's updates, else IDLE.
- A tick in IDLE or ISSUE is ignored and not remembered. Hence at most one dispatch per tick.
- A tick in the same cycle as the first push into an empty FIFO does not dispatch, because the FSM is still in IDLE.
- Latency: push at cycle T, then ARMED at T+1. A tick at T+1 gives cmd_valid at T+2.
- Cooldown:
  - On handshake of a fire command, the counter loads FIRE_COOLDOWN.
  - It decrements by 1 on each tick while nonzero and saturates at 0.
  - A load and a tick in the same cycle: the load wins.
  - fire_busy = (counter != 0).
- Movement commands are never rate-limited beyond the one-per-tick rule.

Test Plan:
- Reset, then push key_op=5'b00100 at T=10 and tick at T=15 → cmd_valid=1 with cmd_op=00100 at T=16. With cmd_ready=1 at T=16, cmd_valid=0 at T=17 and fifo_count=0.
- Push w, a, d, s in consecutive cycles with ticks every 20 cycles and cmd_ready tied high → commands 00100, 01000, 00001, 00010 in order, exactly one per tick.
- Push 5 moves into a DEPTH=4 FIFO with no tick → the 5th push gives a drop pulse, fifo_count=4. Repeat with a pop in the same cycle as the 5th push → accepted, no drop, count stays 4.
- Fire accepted, then a second fire before handshake → second fire dropped (fire_pending). After handshake, fire_busy=1 for 8 ticks; a fire during that window drops. After the 8th tick, fire_busy=0 and fire is accepted.
- Hold cmd_ready=0 for 30 cycles with 3 ticks during ISSUE → cmd_op stable, ticks ignored. Raise cmd_ready → FSM goes to ARMED, and the next command waits for a fresh tick.
- key_op=5'b10100 → no enqueue, no drop. Assert rst while in ISSUE → next cycle cmd_valid=0, fifo_count=0, fire_busy=0.
